// File: rtl/msk_aes_pkg.sv
// Shared definitions for the masked AES-128 key-schedule control slice.
package msk_aes_pkg;

  localparam int unsigned NROUNDS_AES128 = 10;
  localparam int unsigned RCON_W         = 8;
  localparam int unsigned ROUND_W        = 4;

  // RCON[1..10], entry r lives at bits [8*(r-1) +: 8]
  localparam logic [NROUNDS_AES128*RCON_W-1:0] RCON_TABLE = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
    8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } ks_state_e;

  // Round constant for rounds 1..10; any other index yields zero.
  function automatic logic [RCON_W-1:0] rcon_lookup(input logic [ROUND_W-1:0] round);
    logic [RCON_W-1:0] val;
    val = '0;
    for (int unsigned r = 1; r <= NROUNDS_AES128; r++) begin
      if (round == ROUND_W'(r)) begin
        val = RCON_TABLE[RCON_W*(r-1) +: RCON_W];
      end
    end
    return val;
  endfunction

endpackage

// File: rtl/msk_rcon_share.sv
// Bit-interleaved sharing of the round constant (bit i at [D*i +: D]).
// Optional macro MSK_KS_RCON_REMASK_EN: shares 1..D-1 come from rnd_rcon
// and share 0 is corrected so the shares still XOR to the RCON bit.
module msk_rcon_share
  import msk_aes_pkg::*;
#(
  parameter int unsigned D = 2
) (
  input  logic [ROUND_W-1:0]    round_idx,
  input  logic                  en,
`ifdef MSK_KS_RCON_REMASK_EN
  input  logic [8*(D-1)-1:0]    rnd_rcon,
`endif
  output logic [RCON_W*D-1:0]   sh_rcon
);

  logic [RCON_W-1:0] rcon;

  // Build the sharing; all shares are zero when not enabled.
  always_comb begin
    rcon    = en ? rcon_lookup(round_idx) : '0;
    sh_rcon = '0;
    for (int unsigned i = 0; i < RCON_W; i++) begin
`ifdef MSK_KS_RCON_REMASK_EN
      if (en) begin
        sh_rcon[D*i+1 +: D-1] = rnd_rcon[(D-1)*i +: D-1];
        sh_rcon[D*i]          = rcon[i] ^ (^rnd_rcon[(D-1)*i +: D-1]);
      end
`else
      sh_rcon[D*i] = rcon[i];
`endif
    end
  end

endmodule

// File: rtl/msk_aes_ks_ctrl.sv
// Sequencer for the pipelined masked AES-128 key-schedule round.
// Loads the masked key, paces each round over LATENCY cycles, drives the
// shared RCON in the round's last cycle and returns round keys over a
// valid/ready handshake.
// Optional macro MSK_KS_RCON_REMASK_EN adds the rnd_rcon port for a freshly
// remasked RCON sharing.
module msk_aes_ks_ctrl
  import msk_aes_pkg::*;
#(
  parameter int unsigned d       = 2,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned NROUNDS = NROUNDS_AES128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 in_ready,
  output logic                 key_en,
  output logic                 key_sel,
`ifdef MSK_KS_RCON_REMASK_EN
  input  logic [8*(d-1)-1:0]   rnd_rcon,
`endif
  output logic [RCON_W*d-1:0]  sh_rcon,
  output logic [ROUND_W-1:0]   round_idx,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(LATENCY - 1);
  localparam logic [ROUND_W-1:0] ROUND_END = ROUND_W'(NROUNDS);

  ks_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               done_q, done_d;
  logic               rcon_en;

  // State, cycle counter, round counter and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and datapath controls.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    round_d  = round_q;
    done_d   = 1'b0;
    key_en   = 1'b0;
    key_sel  = 1'b0;
    rk_valid = 1'b0;
    rcon_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        key_en  = 1'b1;
        round_d = ROUND_W'(1);
        cnt_d   = '0;
        state_d = ROUND;
      end
      ROUND: begin
        if (cnt_q == CNT_LAST) begin
          rk_valid = 1'b1;
          rcon_en  = 1'b1;
          if (!rk_ready) state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        // Key register untouched, so the round output stays a valid sharing
        rk_valid = 1'b1;
        rcon_en  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Round key accepted: feed it back and advance or finish
    if (rk_valid && rk_ready) begin
      key_en  = 1'b1;
      key_sel = 1'b1;
      cnt_d   = '0;
      if (round_q == ROUND_END) begin
        state_d = IDLE;
        round_d = '0;
        done_d  = 1'b1;
      end else begin
        state_d = ROUND;
        round_d = round_q + ROUND_W'(1);
      end
    end
  end

  // Status outputs derived from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    round_idx = round_q;
    done      = done_q;
  end

  msk_rcon_share #(
    .D (d)
  ) u_rcon_share (
    .round_idx (round_q),
    .en        (rcon_en),
`ifdef MSK_KS_RCON_REMASK_EN
    .rnd_rcon  (rnd_rcon),
`endif
    .sh_rcon   (sh_rcon)
  );

endmodule

// File: tb/tb_msk_aes_ks_ctrl.sv
// Scoreboard bench for msk_aes_ks_ctrl (d=2, LATENCY=4, NROUNDS=10).
module tb_msk_aes_ks_ctrl;

  localparam int unsigned D   = 2;
  localparam int unsigned LAT = 4;
  localparam int unsigned NR  = 10;

  typedef struct {
    int         round;
    logic [7:0] rcon;
    bit         last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_ready, key_en, key_sel, rk_valid, busy, done;
  logic             rk_ready = 1'b1;
  logic [8*D-1:0]   sh_rcon;
  logic [3:0]       round_idx;
`ifdef MSK_KS_RCON_REMASK_EN
  logic [8*(D-1)-1:0] rnd_rcon = '0;
`endif

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   ready_mode = 0;
  exp_t exp_q[$];
  int   launch_q[$];

  msk_aes_ks_ctrl #(.d(D), .LATENCY(LAT), .NROUNDS(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_ready  (in_ready),
    .key_en    (key_en),
    .key_sel   (key_sel),
`ifdef MSK_KS_RCON_REMASK_EN
    .rnd_rcon  (rnd_rcon),
`endif
    .sh_rcon   (sh_rcon),
    .round_idx (round_idx),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // AES round constants by repeated doubling in GF(2^8)
  function automatic logic [7:0] rcon_model(input int r);
    logic [7:0] x;
    x = 8'h01;
    for (int k = 1; k < r; k++) x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    return x;
  endfunction

  function automatic logic [8*D-1:0] share_model(input logic [7:0] v);
    logic [8*D-1:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s[D*i] = v[i];
    return s;
  endfunction

  // Consumer: always ready, random ready, or a 3-cycle stall at round 3
  always @(posedge clk) begin
    static int stall_cnt = 0;
    #1;
    if (!busy) stall_cnt = 0;
    case (ready_mode)
      1: rk_ready = ($urandom_range(3) != 0);
      2: begin
        if (rk_valid && round_idx == 4'd3 && stall_cnt < 3) begin
          rk_ready = 1'b0;
          stall_cnt++;
        end else begin
          rk_ready = 1'b1;
        end
      end
      default: rk_ready = 1'b1;
    endcase
`ifdef MSK_KS_RCON_REMASK_EN
    rnd_rcon = (8*(D-1))'($urandom);
`endif
  end

  // Monitor: compares DUT outputs against the scoreboard
  always @(negedge clk) begin
    static int  next_valid = 0;
    static bit  in_hold = 0;
    static bit  done_pending = 0;
    static int  done_cyc = 0;
    exp_t       e;
    int         lc;
    if (!rst_n) begin
      chk("reset_outputs", {in_ready, busy, key_en, key_sel, rk_valid, done, round_idx, sh_rcon},
          {1'b1, 5'b0, 4'b0, 16'b0});
      exp_q.delete();
      launch_q.delete();
      in_hold = 0;
      done_pending = 0;
    end else begin
      if (key_en && !key_sel) begin
        if (launch_q.size() == 0) chk("unexpected_load", 1, 0);
        else begin
          lc = launch_q.pop_front();
          chk("load_cycle", cyc, lc);
          next_valid = cyc + LAT;
          in_hold = 0;
        end
      end
      if (rk_valid) begin
        if (!in_hold) chk("rk_valid_cycle", cyc, next_valid);
        if (exp_q.size() == 0) chk("unexpected_rk_valid", 1, 0);
        else begin
          e = exp_q[0];
          chk("round_idx", round_idx, e.round);
`ifdef MSK_KS_RCON_REMASK_EN
          begin
            logic [7:0] fold, sh1;
            for (int i = 0; i < 8; i++) begin
              fold[i] = sh_rcon[D*i] ^ sh_rcon[D*i+1];
              sh1[i]  = sh_rcon[D*i+1];
            end
            chk("rcon_xor", fold, e.rcon);
            chk("rcon_rnd_share", sh1, rnd_rcon);
          end
`else
          chk("sh_rcon", sh_rcon, share_model(e.rcon));
`endif
          if (rk_ready) begin
            chk("feedback_en_sel", {key_en, key_sel}, 2'b11);
            void'(exp_q.pop_front());
            in_hold = 0;
            next_valid = cyc + LAT;
            if (e.last) begin
              done_pending = 1;
              done_cyc = cyc + 1;
            end
          end else begin
            chk("hold_key_en", key_en, 0);
            in_hold = 1;
          end
        end
      end else if (busy) begin
        chk("sh_rcon_quiet", sh_rcon, 0);
      end
      if (done_pending && cyc == done_cyc) begin
        chk("done_pulse", done, 1);
        done_pending = 0;
      end else if (done) begin
        chk("unexpected_done", 1, 0);
      end
    end
  end

  // One expansion; optional start poke while busy, optional mid-run abort
  task automatic run_exp(input int mode, input int poke_round, input int abort_round,
                         input bit check_len, input int extra);
    int t0;
    bit finished, poked;
    @(posedge clk); #1;
    chk("in_ready_idle", in_ready, 1);
    ready_mode = mode;
    for (int r = 1; r <= int'(NR); r++) exp_q.push_back('{r, rcon_model(r), r == int'(NR)});
    launch_q.push_back(cyc + 1);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    finished = 0;
    poked = 0;
    for (int k = 0; k < 400 && !finished; k++) begin
      if (poke_round != 0 && int'(round_idx) == poke_round && !poked) begin
        start = 1'b1;
        poked = 1;
      end else begin
        start = 1'b0;
      end
      if (abort_round != 0 && int'(round_idx) == abort_round) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset", {in_ready, busy, key_en, rk_valid, done, round_idx, sh_rcon},
            {1'b1, 4'b0, 4'b0, 16'b0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        finished = 1;
      end else if (done) begin
        finished = 1;
        if (check_len) chk("run_length", cyc - t0, 2 + NR*LAT + extra);
      end
      if (!finished) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    if (!finished) chk("run_timeout", 1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_exp(0, 0, 0, 1, 0);   // back-to-back round keys
    run_exp(2, 0, 0, 1, 3);   // 3-cycle stall at round 3
    run_exp(0, 5, 0, 1, 0);   // start while busy is ignored
    run_exp(0, 0, 6, 0, 0);   // abort during round 6
    run_exp(0, 0, 0, 1, 0);   // clean restart after abort
    for (int i = 0; i < 4; i++) run_exp(1, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size() + launch_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
